// File: rtl/centroid_mean_unit.sv
// k-means centroid update: divides 7 signed coordinate sums by the point count,
// one coordinate per cycle through a shared divider. Define CENTROID_SATURATE_EN
// to clamp each quotient to the signed 13-bit range instead of truncating.
module centroid_mean_unit #(
  parameter int COORD_NUM        = 7,
  parameter int ACCUM_CORD_WIDTH = 22,
  parameter int CORDINATE_WIDTH  = 13,
  parameter int COUNT_WIDTH      = 10,
  parameter int ACCUM_WIDTH      = COORD_NUM * ACCUM_CORD_WIDTH,
  parameter int DATA_WIDTH       = COORD_NUM * CORDINATE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ACCUM_WIDTH-1:0] accumulator,
  input  logic [COUNT_WIDTH-1:0] counter,
  output logic                   busy,
  output logic                   done,
  output logic                   zero_count,
  output logic [DATA_WIDTH-1:0]  new_centroid
);

  localparam int IDX_W = $clog2(COORD_NUM);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ACCUM_WIDTH-1:0] acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  cent_q, cent_d;
  logic                   done_q, done_d;
  logic                   zero_q, zero_d;

  logic signed [ACCUM_CORD_WIDTH-1:0] sum_sel;
  logic signed [ACCUM_CORD_WIDTH-1:0] den;
  logic signed [ACCUM_CORD_WIDTH-1:0] quo;
  logic        [CORDINATE_WIDTH-1:0]  coord;

`ifdef CENTROID_SATURATE_EN
  localparam logic signed [ACCUM_CORD_WIDTH-1:0] SAT_MAX = (ACCUM_CORD_WIDTH'(1) <<< (CORDINATE_WIDTH-1)) - 1;
  localparam logic signed [ACCUM_CORD_WIDTH-1:0] SAT_MIN = -(ACCUM_CORD_WIDTH'(1) <<< (CORDINATE_WIDTH-1));
`endif

  // Shared divider; a zero count is replaced by 1 so the unused quotient stays defined.
  always_comb begin
    sum_sel = '0;
    for (int unsigned k = 0; k < COORD_NUM; k++) begin
      if (idx_q == IDX_W'(k)) sum_sel = acc_q[k*ACCUM_CORD_WIDTH +: ACCUM_CORD_WIDTH];
    end
    den = (cnt_q == '0) ? ACCUM_CORD_WIDTH'(1) : ACCUM_CORD_WIDTH'(cnt_q);
    quo = sum_sel / den;
`ifdef CENTROID_SATURATE_EN
    if (quo > SAT_MAX)      coord = SAT_MAX[CORDINATE_WIDTH-1:0];
    else if (quo < SAT_MIN) coord = SAT_MIN[CORDINATE_WIDTH-1:0];
    else                    coord = quo[CORDINATE_WIDTH-1:0];
`else
    coord = quo[CORDINATE_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cent_d  = cent_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = accumulator;
          cnt_d   = counter;
          zero_d  = (counter == '0);
          idx_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Empty cluster: every field keeps its previous centroid value.
        if (cnt_q != '0) begin
          for (int unsigned k = 0; k < COORD_NUM; k++) begin
            if (idx_q == IDX_W'(k)) cent_d[k*CORDINATE_WIDTH +: CORDINATE_WIDTH] = coord;
          end
        end
        if (idx_q == IDX_W'(COORD_NUM - 1)) state_d = S_FIN;
        else                                idx_d   = idx_q + 1'b1;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cent_q  <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cent_q  <= cent_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign zero_count   = zero_q;
  assign new_centroid = cent_q;

endmodule

// File: tb/tb_centroid_mean_unit.sv
// Scoreboard bench for centroid_mean_unit: expected centroids are queued at start
// and compared, with start-to-done latency, whenever done pulses.
module tb_centroid_mean_unit;

  localparam int AW = 154;
  localparam int DW = 91;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] accumulator;
  logic [CW-1:0] counter;
  logic          busy;
  logic          done;
  logic          zero_count;
  logic [DW-1:0] new_centroid;

  centroid_mean_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .accumulator  (accumulator),
    .counter      (counter),
    .busy         (busy),
    .done         (done),
    .zero_count   (zero_count),
    .new_centroid (new_centroid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] cent;
    logic          zero;
    int            t_done;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_cent;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("centroid", new_centroid, e.cent);
        check("zero_count", zero_count, e.zero);
        check("latency", cyc, e.t_done);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // Drives a one-cycle start at the next negedge and queues the expected result.
  task automatic start_op(input logic [AW-1:0] acc, input logic [CW-1:0] cnt, input logic [DW-1:0] exp_cent);
    exp_t e;
    @(negedge clk);
    accumulator = acc;
    counter     = cnt;
    start       = 1'b1;
    e.cent   = (cnt == '0) ? model_cent : exp_cent;
    e.zero   = (cnt == '0);
    e.t_done = cyc + 9;
    model_cent = e.cent;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic rand_case(output logic [AW-1:0] acc, output logic [CW-1:0] cnt, output logic [DW-1:0] exp_cent);
    int m, r, s;
    cnt = CW'($urandom_range(1, 255));
    acc = '0;
    exp_cent = '0;
    for (int k = 0; k < 7; k++) begin
      m = int'($urandom_range(0, 8191)) - 4096;
      r = int'($urandom_range(0, int'(cnt) - 1));
      s = m * int'(cnt) + ((m >= 0) ? r : -r);
      acc[k*22 +: 22]      = 22'(s);
      exp_cent[k*13 +: 13] = 13'(m);
    end
  endtask

  initial begin
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [DW-1:0] ec;

    rst_n = 1'b0;
    start = 1'b0;
    accumulator = '0;
    counter = '0;
    model_cent = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero_count, 0);
    check("rst_cent", new_centroid, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_cent", new_centroid, 0);

    acc = '0; acc[21:0] = 22'h000E00;
    start_op(acc, 10'd2, 91'h700);
    check("busy_after_start", busy, 1);
    wait_idle();

    acc = '0; acc[21:0] = 22'h000600;
    start_op(acc, 10'd3, 91'd512);
    wait_idle();

    acc = '0; acc[21:0] = 22'h00069D;
    start_op(acc, 10'd13, 91'd130);
    wait_idle();

    acc = '0; acc[21:0] = 22'h3FFA08; acc[65:44] = 22'h3FFC75;
    ec = '0; ec[12:0] = 13'h1F76; ec[38:26] = 13'h1FAE;
    start_op(acc, 10'd11, ec);
    wait_idle();
    repeat (3) @(negedge clk);
    check("stable_after_done", new_centroid, ec);

    // Empty cluster, with a stray start mid-sequence that must be ignored.
    acc = '0; acc[21:0] = 22'h000E00;
    start_op(acc, 10'd0, '0);
    @(negedge clk);
    accumulator = {7{22'h000100}};
    counter = 10'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("zero_keeps_cent", new_centroid, ec);

    // Back-to-back: second start coincides with the first done pulse.
    rand_case(acc, cnt, ec);
    start_op(acc, cnt, ec);
    repeat (7) @(negedge clk);
    rand_case(acc, cnt, ec);
    start_op(acc, cnt, ec);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      rand_case(acc, cnt, ec);
      start_op(acc, cnt, ec);
      wait_idle();
    end

    // Asynchronous reset in the middle of a sequence.
    rand_case(acc, cnt, ec);
    start_op(acc, cnt, ec);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cent", new_centroid, 0);
    check("abort_zero", zero_count, 0);
    sb.delete();
    model_cent = '0;
    @(negedge clk);
    rst_n = 1'b1;

    acc = '0; acc[21:0] = 22'h000E00;
    start_op(acc, 10'd2, 91'h700);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/centroid_mean_unit.md
Name: centroid_mean_unit

Overview:
- Computes the new k-means centroid from a cluster accumulator.
- Splits a packed accumulator into 7 signed 22-bit coordinate sums and divides each by the cluster point count; signed division truncates toward zero.
- Converts each quotient to the 13-bit coordinate format and concatenates the 7 results into one 91-bit centroid word.
- Sits between the accumulation stage and the centroid memory write-back.

Parameters:
- COORD_NUM, 7, coordinates per point.
- ACCUM_CORD_WIDTH, 22, width of one signed coordinate sum.
- CORDINATE_WIDTH, 13, width of one output coordinate (signed, 10 fractional bits).
- COUNT_WIDTH, 10, width of the unsigned point count.
- ACCUM_WIDTH, COORD_NUM*ACCUM_CORD_WIDTH (154), packed accumulator width.
- DATA_WIDTH, COORD_NUM*CORDINATE_WIDTH (91), centroid word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; samples accumulator and counter.
- accumulator  input  ACCUM_WIDTH  7 signed sums; coord 1 in [21:0], coord k in [22k-1:22(k-1)].
- counter  input  COUNT_WIDTH  unsigned divisor (points in cluster).
- busy  output  1  high while a division sequence runs.
- done  output  1  one-cycle pulse; new_centroid is valid and updated.
- zero_count  output  1  registered; set when the last sampled counter was 0.
- new_centroid  output  DATA_WIDTH  {c7,...,c1}; c1 in [12:0].

Behaviour:
- Reset (async, rst_n low): busy=0, done=0, zero_count=0, new_centroid=0, internal index=0, latched operands=0.
- Idle plus start: latch accumulator and counter; set busy=1, index=0. In the same edge, zero_count <= (counter==0).
- start while busy is ignored; the latched operands are not disturbed.
- Busy, one coordinate per cycle in the order index 0..6 (c1..c7), using one shared combinational signed divider:
  - q = signed(sum_k) / signed({1'b0,count}), truncated toward zero.
  - The remainder is discarded.
- Conversion: c_k = q[12:0], truncation of the upper bits. Sums are averages of 13-bit values, so they fit.
- Each c_k is written into its new_centroid field at the cycle it is computed.
- count==0: the divider is bypassed and every field keeps its previous value (empty cluster keeps its centroid). The sequence still runs the full 7 cycles and done still pulses.
- After index 6 is written: busy=0, done=1 for exactly one cycle. Latency from start to done is 8 cycles (start at edge 0, done high after edge 8).
- new_centroid is stable between done pulses. During busy it is partially updated, so consumers use it only at or after done.
- start on the same cycle as done: accepted, and a new sequence begins.
- Reset mid-sequence: aborts immediately and all outputs return to reset values.
- The divider is purely combinational between registers. No multicycle paths.

Optional Feature:
- Macro: CENTROID_SATURATE_EN.
- Defined: each quotient is saturated to the signed 13-bit range [-4096, 4095] before packing.
- Not defined: plain truncation to q[12:0], as specified above. Results are identical for all in-range quotients.

Test Plan:
- Reset: hold rst_n low -> busy=0, done=0, new_centroid=0. Release, and outputs stay 0 with no start.
- coord1 sum=3584 (22'h000E00), others 0, counter=2, start -> done after 8 cycles; c1=13'h0700 (1792), others 0.
- coord1 sum=1536 (22'h000600), counter=3 -> c1=512. coord1 sum=1693 (22'h00069D), counter=13 -> c1=130 (0.127 in Q.10).
- Negatives: coord1=22'h3FFA08 (-1528), coord3=22'h3FFC75 (-907), others 0, counter=11 -> c1=13'h1F76 (-138), c3=13'h1FAE (-82), c2=c4..c7=0. Truncation is toward zero, not floor.
- counter=0 after the previous test -> zero_count=1, new_centroid unchanged, done pulses at cycle 8. Extra start pulses during busy are ignored.
- Assert rst_n low at cycle 4 of a sequence -> busy, done and new_centroid go to 0 asynchronously. A fresh start afterwards completes normally.
